// File: rtl/attack_pool.sv
// Multi-slot projectile manager: spawns projectiles from the player on the fire key, moves and
// retires them once per frame tick, and reports which projectile covers the pixel being drawn.
module attack_pool #(
    parameter int NUM_SLOTS = 4,
    parameter int OBJ_W     = 16,
    parameter int OBJ_H     = 16,
    parameter int SPEED     = 4,
    parameter int COOLDOWN  = 8,
    parameter int LIFETIME  = 32,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int FIRE_KEY  = 44,
    localparam int AW = $clog2(OBJ_W * OBJ_H),
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int CW = $clog2(NUM_SLOTS + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_clk,
    input  logic [7:0]    keycode,
    input  logic [9:0]    Player_X,
    input  logic [9:0]    Player_Y,
    input  logic [1:0]    Player_Direction,
    input  logic [9:0]    PixelX,
    input  logic [9:0]    PixelY,
    output logic          is_obj,
    output logic [AW-1:0] Obj_address,
    output logic [SW-1:0] Obj_slot,
    output logic [CW-1:0] active_count,
    output logic          fire_pulse
);

    localparam int LW = $clog2(LIFETIME + 1);
    localparam int DW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [9:0]  STEP   = 10'(SPEED);
    localparam logic [10:0] STEP11 = 11'(SPEED);
    localparam logic [10:0] REACH_X = 11'(SPEED + OBJ_W);
    localparam logic [10:0] REACH_Y = 11'(SPEED + OBJ_H);
    localparam logic [10:0] LIM_X  = 11'(SCREEN_W);
    localparam logic [10:0] LIM_Y  = 11'(SCREEN_H);
    localparam logic [10:0] W11    = 11'(OBJ_W);
    localparam logic [10:0] H11    = 11'(OBJ_H);

    logic [1:0]           fc_sync;
    logic                 tick;
    logic [NUM_SLOTS-1:0] active;
    logic [9:0]           pos_x [NUM_SLOTS];
    logic [9:0]           pos_y [NUM_SLOTS];
    logic [1:0]           dir   [NUM_SLOTS];
    logic [LW-1:0]        life  [NUM_SLOTS];
    logic [DW-1:0]        cooldown;
    logic [NUM_SLOTS-1:0] leaving;
    logic [NUM_SLOTS-1:0] hit;
    logic [10:0]          dx [NUM_SLOTS];
    logic [10:0]          dy [NUM_SLOTS];
    logic [SW-1:0]        free_idx;
    logic                 fire;
    logic [9:0]           spawn_x;
    logic [9:0]           spawn_y;

    function automatic logic [CW-1:0] count_ones(input logic [NUM_SLOTS-1:0] v);
        count_ones = '0;
        for (int i = 0; i < NUM_SLOTS; i++) count_ones = count_ones + CW'(v[i]);
    endfunction

    // frame_clk is an asynchronous level; its rising edge becomes a single-cycle tick.
    assign tick = fc_sync[0] & ~fc_sync[1];

    always_comb begin
        leaving = '0;
        hit     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            case (dir[i])
                2'd0:    leaving[i] = ({1'b0, pos_y[i]} + REACH_Y) > LIM_Y;
                2'd1:    leaving[i] = {1'b0, pos_x[i]} < STEP11;
                2'd2:    leaving[i] = {1'b0, pos_y[i]} < STEP11;
                default: leaving[i] = ({1'b0, pos_x[i]} + REACH_X) > LIM_X;
            endcase
            dx[i]  = {1'b0, PixelX} - {1'b0, pos_x[i]};
            dy[i]  = {1'b0, PixelY} - {1'b0, pos_y[i]};
            hit[i] = active[i] && (PixelX >= pos_x[i]) && (PixelY >= pos_y[i])
                     && (dx[i] < W11) && (dy[i] < H11);
        end
    end

    always_comb begin
        spawn_x = Player_X + 10'd36;
        spawn_y = Player_Y + 10'd30;
        case (Player_Direction)
            2'd0: begin spawn_x = Player_X + 10'd2;  spawn_y = Player_Y + 10'd40; end
            2'd1: begin spawn_x = Player_X;          spawn_y = Player_Y + 10'd10; end
            2'd2: begin spawn_x = Player_X + 10'd36; spawn_y = Player_Y + 10'd2;  end
            default: ;
        endcase
        // NOTE: scanning downward with blocking assignments leaves the lowest free index; a
        // variable assigned on every path first keeps this block free of latches.
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) if (!active[i]) free_idx = SW'(i);
        fire = (keycode == 8'(FIRE_KEY)) && (cooldown == '0) && !(&active);
    end

    always_comb begin
        is_obj      = 1'b0;
        Obj_slot    = '0;
        Obj_address = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                is_obj      = 1'b1;
                Obj_slot    = SW'(i);
                Obj_address = AW'(dx[i] + dy[i] * W11);
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every slot sees the pre-tick values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_sync      <= '0;
            active       <= '0;
            cooldown     <= '0;
            fire_pulse   <= 1'b0;
            active_count <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                dir[i]   <= '0;
                life[i]  <= '0;
            end
        end else begin
            fc_sync      <= {fc_sync[0], frame_clk};
            fire_pulse   <= tick && fire;
            active_count <= count_ones(active);
            if (tick) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (active[i]) begin
                        if (life[i] == LW'(1) || leaving[i]) begin
                            active[i] <= 1'b0;
                        end else begin
                            case (dir[i])
                                2'd0:    pos_y[i] <= pos_y[i] + STEP;
                                2'd1:    pos_x[i] <= pos_x[i] - STEP;
                                2'd2:    pos_y[i] <= pos_y[i] - STEP;
                                default: pos_x[i] <= pos_x[i] + STEP;
                            endcase
                            life[i] <= life[i] - LW'(1);
                        end
                    end
                end
                // The chosen slot was inactive before this tick, so it never collides with a move.
                if (fire) begin
                    active[free_idx] <= 1'b1;
                    pos_x[free_idx]  <= spawn_x;
                    pos_y[free_idx]  <= spawn_y;
                    dir[free_idx]    <= Player_Direction;
                    life[free_idx]   <= LW'(LIFETIME);
                    cooldown         <= DW'(COOLDOWN);
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_attack_pool.sv
// Self-checking bench for attack_pool: directed scenarios plus randomized ticks compared
// against a behavioural slot model kept in plain integers.
module tb_attack_pool;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] Player_X, Player_Y, PixelX, PixelY;
    logic [1:0] Player_Direction;
    logic       is_obj;
    logic [7:0] Obj_address;
    logic [1:0] Obj_slot;
    logic [2:0] active_count;
    logic       fire_pulse;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the four slots.
    int m_act [4];
    int m_x   [4];
    int m_y   [4];
    int m_dir [4];
    int m_life[4];
    int m_cd;
    int off_x [4] = '{2, 0, 36, 36};
    int off_y [4] = '{40, 10, 2, 30};

    attack_pool dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .Player_X(Player_X), .Player_Y(Player_Y), .Player_Direction(Player_Direction),
        .PixelX(PixelX), .PixelY(PixelY), .is_obj(is_obj), .Obj_address(Obj_address),
        .Obj_slot(Obj_slot), .active_count(active_count), .fire_pulse(fire_pulse)
    );

    always #5 Clk = ~Clk;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_life[i] = 0;
        end
        m_cd = 0;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 4; i++) n += m_act[i];
        return n;
    endfunction

    // One frame tick of the rules, using the inputs currently driven.
    task automatic model_tick(output int fired);
        int free = -1;
        for (int i = 0; i < 4; i++) if (!m_act[i] && free < 0) free = i;
        fired = (keycode == 8'd44 && m_cd == 0 && free >= 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            if (m_act[i]) begin
                if (m_life[i] == 1) m_act[i] = 0;
                else if (m_dir[i] == 0 && m_y[i] + 4 + 16 > 480) m_act[i] = 0;
                else if (m_dir[i] == 1 && m_x[i] < 4) m_act[i] = 0;
                else if (m_dir[i] == 2 && m_y[i] < 4) m_act[i] = 0;
                else if (m_dir[i] == 3 && m_x[i] + 4 + 16 > 640) m_act[i] = 0;
                else begin
                    if (m_dir[i] == 0) m_y[i] += 4;
                    if (m_dir[i] == 1) m_x[i] -= 4;
                    if (m_dir[i] == 2) m_y[i] -= 4;
                    if (m_dir[i] == 3) m_x[i] += 4;
                    m_life[i] -= 1;
                end
            end
        end
        if (fired == 1) begin
            m_act[free]  = 1;
            m_dir[free]  = int'(Player_Direction);
            m_x[free]    = int'(Player_X) + off_x[m_dir[free]];
            m_y[free]    = int'(Player_Y) + off_y[m_dir[free]];
            m_life[free] = 32;
            m_cd = 8;
        end else if (m_cd > 0) begin
            m_cd -= 1;
        end
    endtask

    // Drives pixel, returns what the model says should be drawn there.
    task automatic probe(input int px, input int py, output int eh, output int es, output int ea);
        PixelX = 10'(px);
        PixelY = 10'(py);
        #1;
        eh = 0; es = 0; ea = 0;
        for (int i = 3; i >= 0; i--) begin
            if (m_act[i] && px >= m_x[i] && px < m_x[i] + 16 && py >= m_y[i] && py < m_y[i] + 16) begin
                eh = 1; es = i; ea = (px - m_x[i]) + (py - m_y[i]) * 16;
            end
        end
    endtask

    // Pulses frame_clk for a few cycles and counts fire_pulse cycles around it.
    task automatic do_tick(input int high_cycles, output int pulses);
        pulses = 0;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (high_cycles) begin @(posedge Clk); #1; pulses += int'(fire_pulse); end
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) begin @(posedge Clk); #1; pulses += int'(fire_pulse); end
    endtask

    task automatic apply_tick(output int exp_fire, output int pulses);
        model_tick(exp_fire);
        do_tick(4, pulses);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int eh, es, ea;
        probe(0, 0, eh, es, ea);
        checks += 4;
        if (is_obj !== 1'b0)       begin errors++; $display("FAIL reset_is_obj: got %b expected 0", is_obj); end
        if (Obj_address !== 8'd0)  begin errors++; $display("FAIL reset_addr: got %0d expected 0", Obj_address); end
        if (active_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", active_count); end
        if (fire_pulse !== 1'b0)   begin errors++; $display("FAIL reset_fire: got %b expected 0", fire_pulse); end
    endtask

    task automatic test_first_shot();
        int ef, p, eh, es, ea;
        keycode = 8'd44; Player_Direction = 2'd3; Player_X = 10'd100; Player_Y = 10'd200;
        apply_tick(ef, p);
        checks += 2;
        if (p != 1)                begin errors++; $display("FAIL first_pulse: got %0d cycles expected 1", p); end
        if (active_count !== 3'd1) begin errors++; $display("FAIL first_count: got %0d expected 1", active_count); end
        probe(136, 230, eh, es, ea);
        checks++;
        if (is_obj !== 1'b1 || Obj_slot !== 2'd0 || Obj_address !== 8'd0) begin
            errors++; $display("FAIL first_origin: got %b/%0d/%0d expected 1/0/0", is_obj, Obj_slot, Obj_address);
        end
        probe(151, 245, eh, es, ea);
        checks++;
        if (is_obj !== 1'b1 || Obj_address !== 8'd255) begin
            errors++; $display("FAIL first_corner: got %b/%0d expected 1/255", is_obj, Obj_address);
        end
        probe(152, 230, eh, es, ea);
        checks++;
        if (is_obj !== 1'b0) begin errors++; $display("FAIL first_right_edge: got %b expected 0", is_obj); end
    endtask

    task automatic test_hold_fill();
        int ef, p, eh, es, ea;
        for (int t = 1; t < 40; t++) begin
            if (t == 9) Player_X = 10'd140;
            apply_tick(ef, p);
            checks += 2;
            if (p != ef) begin errors++; $display("FAIL hold_pulse t%0d: got %0d expected %0d", t, p, ef); end
            if (active_count !== 3'(model_count())) begin
                errors++; $display("FAIL hold_count t%0d: got %0d expected %0d", t, active_count, model_count());
            end
            if (t == 9) begin
                probe(186, 240, eh, es, ea);
                checks++;
                if (is_obj !== 1'b1 || Obj_slot !== 2'd0 || Obj_address !== 8'd174) begin
                    errors++; $display("FAIL overlap: got %b/%0d/%0d expected 1/0/174", is_obj, Obj_slot, Obj_address);
                end
            end
            if (t == 27 || t == 32) begin
                checks++;
                if (active_count !== ((t == 27) ? 3'd4 : 3'd3)) begin
                    errors++; $display("FAIL hold_full t%0d: got %0d", t, active_count);
                end
            end
        end
    endtask

    task automatic test_edge_retire();
        int ef, p, eh, es, ea;
        do_reset();
        keycode = 8'd44; Player_Direction = 2'd1; Player_X = 10'd2; Player_Y = 10'd100;
        apply_tick(ef, p);
        probe(2, 110, eh, es, ea);
        checks += 2;
        if (p != 1)          begin errors++; $display("FAIL edge_spawn_pulse: got %0d expected 1", p); end
        if (is_obj !== 1'b1) begin errors++; $display("FAIL edge_spawn_hit: got %b expected 1", is_obj); end
        keycode = 8'd0;
        for (int t = 0; t < 3; t++) begin
            apply_tick(ef, p);
            probe(2, 110, eh, es, ea);
            checks += 2;
            if (is_obj !== 1'b0)       begin errors++; $display("FAIL edge_gone t%0d: got %b expected 0", t, is_obj); end
            if (active_count !== 3'd0) begin errors++; $display("FAIL edge_count t%0d: got %0d expected 0", t, active_count); end
        end
    endtask

    task automatic test_reset_midflight();
        int ef, p, eh, es, ea;
        do_reset();
        keycode = 8'd44; Player_Direction = 2'd0; Player_X = 10'd50; Player_Y = 10'd50;
        for (int t = 0; t < 19; t++) apply_tick(ef, p);
        checks++;
        if (active_count !== 3'd3) begin errors++; $display("FAIL mid_live: got %0d expected 3", active_count); end
        PixelX = 10'd52; PixelY = 10'd90;
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        checks += 2;
        if (is_obj !== 1'b0)       begin errors++; $display("FAIL mid_reset_obj: got %b expected 0", is_obj); end
        if (active_count !== 3'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", active_count); end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        apply_tick(ef, p);
        checks += 2;
        if (p != 1)                begin errors++; $display("FAIL mid_refire: got %0d expected 1", p); end
        if (active_count !== 3'd1) begin errors++; $display("FAIL mid_refire_count: got %0d expected 1", active_count); end
    endtask

    task automatic test_long_high();
        int ef, p, eh, es, ea;
        keycode = 8'd0;
        model_tick(ef);
        do_tick(1000, p);
        checks++;
        if (p != 0) begin errors++; $display("FAIL long_pulse: got %0d expected 0", p); end
        probe(52, 94, eh, es, ea);
        checks++;
        if (is_obj !== 1'b1 || Obj_address !== 8'd0) begin
            errors++; $display("FAIL long_moved: got %b/%0d expected 1/0", is_obj, Obj_address);
        end
        probe(52, 93, eh, es, ea);
        checks++;
        if (is_obj !== 1'b0) begin errors++; $display("FAIL long_once: got %b expected 0", is_obj); end
    endtask

    task automatic test_random();
        int ef, p, eh, es, ea, px, py;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
                checks++;
                if (active_count !== 3'd0) begin errors++; $display("FAIL rnd_reset t%0d: got %0d", t, active_count); end
            end
            keycode = ($urandom_range(0, 3) != 0) ? 8'd44 : 8'($urandom_range(0, 43));
            Player_Direction = 2'($urandom_range(0, 3));
            Player_X = 10'($urandom_range(0, 600));
            Player_Y = 10'($urandom_range(0, 430));
            apply_tick(ef, p);
            checks += 2;
            if (p != ef) begin errors++; $display("FAIL rnd_pulse t%0d: got %0d expected %0d", t, p, ef); end
            if (active_count !== 3'(model_count())) begin
                errors++; $display("FAIL rnd_count t%0d: got %0d expected %0d", t, active_count, model_count());
            end
            for (int k = 0; k < 6; k++) begin
                if (k < 4 && m_act[k]) begin
                    px = m_x[k] + int'($urandom_range(0, 17));
                    py = m_y[k] + int'($urandom_range(0, 17));
                end else begin
                    px = int'($urandom_range(0, 639));
                    py = int'($urandom_range(0, 479));
                end
                probe(px, py, eh, es, ea);
                checks++;
                if (is_obj !== 1'(eh) || Obj_slot !== 2'(es) || Obj_address !== 8'(ea)) begin
                    errors++;
                    $display("FAIL rnd_pixel t%0d (%0d,%0d): got %b/%0d/%0d expected %0d/%0d/%0d",
                             t, px, py, is_obj, Obj_slot, Obj_address, eh, es, ea);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'd0;
        Player_X = '0; Player_Y = '0; Player_Direction = '0; PixelX = '0; PixelY = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        test_reset();
        test_first_shot();
        test_hold_fill();
        test_edge_retire();
        test_reset_midflight();
        test_long_high();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
